exc_arbiter: RTL and testbench
==============================

Name: exc_arbiter

Overview:
- Memory-stage exception arbiter. It sits directly upstream of the CP0 block.
- It collects the exception flags carried down the pipeline with each instruction, and the interrupt request from CP0.
- It selects one event per cycle by MIPS priority and drives CP0's exception inputs (isException, cause, PC, BD, BadVAddr).
- It sequences the pipeline flush that follows a taken exception, defers interrupts that arrive on pipeline bubbles, and reports whether any exception is still in flight.

Parameters:
- FLUSH_CYCLES, 2, cycles that flush stays high after a taken event (1..7).
- CAUSE_ERET, 5'd31, pseudo-cause code that CP0 decodes as ERET.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_valid  in  1  M stage holds a real instruction (0 = bubble)
- m_pc  in  32  PC of the M-stage instruction
- m_is_bd  in  1  M-stage instruction is in a branch delay slot
- m_exc_fetch  in  1  instruction-fetch address error (AdEL)
- m_exc_ri  in  1  reserved instruction
- m_exc_sys  in  1  syscall
- m_exc_bp  in  1  break
- m_exc_ov  in  1  arithmetic overflow
- m_exc_load  in  1  data load address error (AdEL)
- m_exc_store  in  1  data store address error (AdES)
- m_is_eret  in  1  ERET instruction
- m_data_addr  in  32  data address of the M-stage load/store
- upstream_exc  in  1  OR of exception flags currently in F/D/E stages
- irq  in  1  interrupt request from CP0 (interruptNow)
- exc_valid  out  1  to CP0 isException
- exc_cause  out  5  to CP0 exceptionCause
- exc_pc  out  32  to CP0 exceptionPC
- exc_bd  out  1  to CP0 isBD
- exc_badvaddr  out  32  to CP0 exceptionBadVAddr
- flush  out  1  kill F/D/E/M and suppress M-stage writeback
- exc_in_pipeline  out  1  to CP0 hasExceptionInPipeline
- irq_pending  out  1  debug: an interrupt is latched and waiting

Behaviour:
- Reset: state=IDLE, irq latch=0, flush counter=0.
  - All outputs 0, except exc_pc and exc_badvaddr, which are 0 and don't-care.
- States: IDLE, IRQ_WAIT, FLUSH.
- Exception outputs are combinational from state and M-stage inputs.
  - Event detected in cycle N gives exc_valid=1 in cycle N, so CP0 latches it at the N→N+1 edge.
- Event candidates exist only in IDLE or IRQ_WAIT.
- Priority, highest first:
  1. Interrupt: cause 0. Requires (irq or latch) and m_valid.
  2. Fetch AdEL: cause 4, badvaddr=m_pc.
  3. RI: cause 10.
  4. Syscall: cause 8.
  5. Break: cause 9.
  6. Overflow: cause 12.
  7. Data AdEL: cause 4, badvaddr=m_data_addr.
  8. Data AdES: cause 5, badvaddr=m_data_addr.
  9. ERET: cause CAUSE_ERET.
- All synchronous flags are ignored when m_valid=0.
- exc_pc=m_pc and exc_bd=m_is_bd for every event. CP0 applies the BD −4 correction.
- exc_badvaddr is 0 for events without an address.
- IDLE:
  - Event selected → FLUSH, counter=FLUSH_CYCLES−1, irq latch cleared.
  - irq=1 and m_valid=0 → IRQ_WAIT, latch=1. No event this cycle; the bubble has no valid EPC.
- IRQ_WAIT:
  - Latch holds even if irq drops.
  - First cycle with m_valid=1 → interrupt event (priority 1) → FLUSH.
  - reset → IDLE.
- FLUSH:
  - flush=1, exc_valid=0; all inputs, including irq, are ignored.
  - Counter decrements each cycle; at 0, next cycle → IDLE.
- flush=1 also in the event cycle itself, so M writeback of the faulting instruction is suppressed.
  - Exception: ERET does not self-suppress; its M write is a no-op.
- exc_in_pipeline = upstream_exc | (m_valid & any M flag) | (state≠IDLE).
- irq_pending = latch.
- Reset in FLUSH or IRQ_WAIT: IDLE next cycle, latch cleared, no event.

Test Plan:
- Reset held 3 cycles with all flags=1 → all outputs 0. Release with all inputs 0 → exc_valid stays 0.
- m_valid=1, m_pc=0x00400010, m_exc_ov=1, m_exc_store=1, m_data_addr=0x1001 → exc_valid=1, cause=12, badvaddr=0.
  - Then flush=1 for exactly 2 cycles; a second ov in those cycles is ignored.
- m_valid=1, m_exc_fetch=1, m_pc=0x00400003, m_is_bd=1 → cause=4, exc_pc=0x00400003, exc_bd=1, badvaddr=0x00400003.
- irq=1 for 1 cycle with m_valid=0, then 2 bubbles, then m_valid=1, m_pc=0x00400020 → irq_pending=1 across bubbles.
  - Event fires on the valid cycle: cause=0, pc=0x00400020. irq_pending then 0.
- irq=1 and m_exc_ri=1 on the same valid cycle → cause=0 (interrupt wins).
  - m_is_eret=1 alone → cause=31.
- Reset asserted during FLUSH counter=1 and during IRQ_WAIT → next cycle flush=0, irq_pending=0, no exc_valid.

Source files
------------

// File: rtl/exc_arbiter.sv
// exc_arbiter: memory-stage exception arbiter feeding CP0.
// Picks one event per cycle, sequences the flush, defers bubble irqs.
module exc_arbiter #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  CAUSE_ERET   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_is_bd,
  input  logic        m_exc_fetch,
  input  logic        m_exc_ri,
  input  logic        m_exc_sys,
  input  logic        m_exc_bp,
  input  logic        m_exc_ov,
  input  logic        m_exc_load,
  input  logic        m_exc_store,
  input  logic        m_is_eret,
  input  logic [31:0] m_data_addr,
  input  logic        upstream_exc,
  input  logic        irq,
  output logic        exc_valid,
  output logic [4:0]  exc_cause,
  output logic [31:0] exc_pc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        exc_in_pipeline,
  output logic        irq_pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IRQ_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  localparam logic [4:0] C_INT = 5'd0;
  localparam logic [4:0] C_ADEL = 5'd4;
  localparam logic [4:0] C_ADES = 5'd5;
  localparam logic [4:0] C_SYS = 5'd8;
  localparam logic [4:0] C_BP = 5'd9;
  localparam logic [4:0] C_RI = 5'd10;
  localparam logic [4:0] C_OV = 5'd12;

  state_t     state;
  state_t     state_nx;
  logic       latch;
  logic       latch_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;

  logic open_win;
  logic sync_ok;
  logic any_flag;

  logic c_int;
  logic c_fetch;
  logic c_ri;
  logic c_sys;
  logic c_bp;
  logic c_ov;
  logic c_load;
  logic c_store;
  logic c_eret;

  logic        sel;
  logic        sel_eret;
  logic [4:0]  sel_cause;
  logic [31:0] sel_badv;

  // Events may only be raised outside the flush window and out of reset.
  assign open_win = !reset && (state != FLUSH);
  assign sync_ok  = open_win && m_valid;

  assign any_flag = m_exc_fetch | m_exc_ri | m_exc_sys
                  | m_exc_bp | m_exc_ov | m_exc_load
                  | m_exc_store | m_is_eret;

  // A bubble carries no EPC, so the interrupt also waits for m_valid.
  assign c_int   = sync_ok && (irq || latch);
  assign c_fetch = sync_ok && m_exc_fetch;
  assign c_ri    = sync_ok && m_exc_ri;
  assign c_sys   = sync_ok && m_exc_sys;
  assign c_bp    = sync_ok && m_exc_bp;
  assign c_ov    = sync_ok && m_exc_ov;
  assign c_load  = sync_ok && m_exc_load;
  assign c_store = sync_ok && m_exc_store;
  assign c_eret  = sync_ok && m_is_eret;

  // Priority select: first matching candidate wins.
  always_comb begin
    sel       = 1'b0;
    sel_eret  = 1'b0;
    sel_cause = '0;
    sel_badv  = '0;
    priority case (1'b1)
      c_int: begin
        sel       = 1'b1;
        sel_cause = C_INT;
      end
      c_fetch: begin
        sel       = 1'b1;
        sel_cause = C_ADEL;
        sel_badv  = m_pc;
      end
      c_ri: begin
        sel       = 1'b1;
        sel_cause = C_RI;
      end
      c_sys: begin
        sel       = 1'b1;
        sel_cause = C_SYS;
      end
      c_bp: begin
        sel       = 1'b1;
        sel_cause = C_BP;
      end
      c_ov: begin
        sel       = 1'b1;
        sel_cause = C_OV;
      end
      c_load: begin
        sel       = 1'b1;
        sel_cause = C_ADEL;
        sel_badv  = m_data_addr;
      end
      c_store: begin
        sel       = 1'b1;
        sel_cause = C_ADES;
        sel_badv  = m_data_addr;
      end
      c_eret: begin
        sel       = 1'b1;
        sel_eret  = 1'b1;
        sel_cause = CAUSE_ERET;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

  // State, irq latch and flush counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      latch <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      latch <= latch_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: enter flush on an event, park bubble irqs in IRQ_WAIT.
  always_comb begin
    state_nx = state;
    latch_nx = latch;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (sel) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_INIT;
          latch_nx = 1'b0;
        end else if (irq && !m_valid) begin
          state_nx = IRQ_WAIT;
          latch_nx = 1'b1;
        end
      end
      IRQ_WAIT: begin
        if (sel) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_INIT;
          latch_nx = 1'b0;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        latch_nx = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end

  // CP0-facing outputs; ERET is left to retire its no-op write.
  always_comb begin
    exc_valid    = sel;
    exc_cause    = sel_cause;
    exc_pc       = sel ? m_pc : '0;
    exc_bd       = sel && m_is_bd;
    exc_badvaddr = sel_badv;
    flush        = !reset
                && ((state == FLUSH) || (sel && !sel_eret));
    exc_in_pipeline = !reset
                   && (upstream_exc
                    || (m_valid && any_flag)
                    || (state != IDLE));
    irq_pending  = latch && !reset;
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// tb_exc_arbiter: directed and randomized checks of exc_arbiter
// against a cycle-level reference model.
module tb_exc_arbiter;

  localparam int FLUSH_CYCLES = 2;
  localparam logic [4:0] CAUSE_ERET = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_is_bd;
  logic        m_exc_fetch;
  logic        m_exc_ri;
  logic        m_exc_sys;
  logic        m_exc_bp;
  logic        m_exc_ov;
  logic        m_exc_load;
  logic        m_exc_store;
  logic        m_is_eret;
  logic [31:0] m_data_addr;
  logic        upstream_exc;
  logic        irq;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        flush;
  logic        exc_in_pipeline;
  logic        irq_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: remaining flush cycles, deferred irq
  int fl_left = 0;
  bit lat = 1'b0;

  // model expectations for the current cycle
  bit        e_valid;
  bit [4:0]  e_cause;
  bit [31:0] e_pc;
  bit        e_bd;
  bit [31:0] e_badv;
  bit        e_flush;
  bit        e_inp;
  bit        e_pend;

  exc_arbiter #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CAUSE_ERET(CAUSE_ERET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m_valid(m_valid),
    .m_pc(m_pc),
    .m_is_bd(m_is_bd),
    .m_exc_fetch(m_exc_fetch),
    .m_exc_ri(m_exc_ri),
    .m_exc_sys(m_exc_sys),
    .m_exc_bp(m_exc_bp),
    .m_exc_ov(m_exc_ov),
    .m_exc_load(m_exc_load),
    .m_exc_store(m_exc_store),
    .m_is_eret(m_is_eret),
    .m_data_addr(m_data_addr),
    .upstream_exc(upstream_exc),
    .irq(irq),
    .exc_valid(exc_valid),
    .exc_cause(exc_cause),
    .exc_pc(exc_pc),
    .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr),
    .flush(flush),
    .exc_in_pipeline(exc_in_pipeline),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_valid      = 0;
    m_pc         = 0;
    m_is_bd      = 0;
    m_exc_fetch  = 0;
    m_exc_ri     = 0;
    m_exc_sys    = 0;
    m_exc_bp     = 0;
    m_exc_ov     = 0;
    m_exc_load   = 0;
    m_exc_store  = 0;
    m_is_eret    = 0;
    m_data_addr  = 0;
    upstream_exc = 0;
    irq          = 0;
  endtask

  // Expected outputs from the MIPS priority rules.
  task automatic model_eval();
    bit        req [9];
    bit [4:0]  cs  [9];
    bit        any;
    int        hit;
    cs = '{5'd0, 5'd4, 5'd10, 5'd8, 5'd9,
           5'd12, 5'd4, 5'd5, CAUSE_ERET};
    e_valid = 0; e_cause = 0; e_pc = 0; e_bd = 0;
    e_badv = 0; e_flush = 0; e_inp = 0; e_pend = 0;
    if (!reset) begin
      e_pend = lat;
      any = m_exc_fetch | m_exc_ri | m_exc_sys | m_exc_bp
          | m_exc_ov | m_exc_load | m_exc_store | m_is_eret;
      e_inp = upstream_exc | (m_valid & any) | lat | (fl_left > 0);
      if (fl_left > 0) begin
        e_flush = 1;
      end else if (m_valid) begin
        req = '{irq | lat, m_exc_fetch, m_exc_ri, m_exc_sys,
                m_exc_bp, m_exc_ov, m_exc_load, m_exc_store,
                m_is_eret};
        hit = -1;
        for (int i = 8; i >= 0; i--)
          if (req[i]) hit = i;
        if (hit >= 0) begin
          e_valid = 1;
          e_cause = cs[hit];
          e_pc    = m_pc;
          e_bd    = m_is_bd;
          e_flush = (hit != 8);
          if (hit == 1) e_badv = m_pc;
          else if (hit == 6 || hit == 7) e_badv = m_data_addr;
        end
      end
    end
  endtask

  task automatic model_step();
    if (reset) begin
      fl_left = 0;
      lat = 0;
    end else if (fl_left > 0) begin
      fl_left--;
    end else if (e_valid) begin
      fl_left = FLUSH_CYCLES;
      lat = 0;
    end else if (irq && !m_valid) begin
      lat = 1;
    end
  endtask

  // advance one clock, keeping the model in step
  task automatic tick();
    model_eval();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    m_valid = 1; m_pc = 32'hFFFF_FFFF; m_is_bd = 1;
    m_exc_fetch = 1; m_exc_ri = 1; m_exc_sys = 1; m_exc_bp = 1;
    m_exc_ov = 1; m_exc_load = 1; m_exc_store = 1; m_is_eret = 1;
    m_data_addr = 32'hFFFF_FFFF; upstream_exc = 1; irq = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({exc_valid, exc_cause, exc_pc, exc_bd, exc_badvaddr,
           flush, exc_in_pipeline, irq_pending} !== '0) begin
        n_bad++;
        $display("FAIL reset_outs: got v=%0b c=%0d pc=%0h f=%0b p=%0b q=%0b want all 0",
                 exc_valid, exc_cause, exc_pc, flush,
                 exc_in_pipeline, irq_pending);
      end
      tick();
    end
    reset = 0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (exc_valid !== 1'b0 || flush !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_idle: got v=%0b f=%0b want 0 0",
                 exc_valid, flush);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    clear_inputs();
    m_valid = 1; m_pc = 32'h0040_0010;
    m_exc_ov = 1; m_exc_store = 1; m_data_addr = 32'h1001;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 1 || exc_cause !== 5'd12 ||
        exc_badvaddr !== 0 || exc_pc !== 32'h0040_0010 ||
        flush !== 1) begin
      n_bad++;
      $display("FAIL ov_event: got v=%0b c=%0d bv=%0h pc=%0h f=%0b want 1 12 0 400010 1",
               exc_valid, exc_cause, exc_badvaddr, exc_pc, flush);
    end
    tick();
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      @(negedge clk);
      n_cmp++;
      if (flush !== 1 || exc_valid !== 0) begin
        n_bad++;
        $display("FAIL ov_flush%0d: got f=%0b v=%0b want 1 0",
                 i, flush, exc_valid);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (flush !== 0 || exc_valid !== 0) begin
      n_bad++;
      $display("FAIL ov_flush_end: got f=%0b v=%0b want 0 0",
               flush, exc_valid);
    end
    tick();
  endtask

  task automatic test_fetch();
    clear_inputs();
    m_valid = 1; m_exc_fetch = 1; m_pc = 32'h0040_0003; m_is_bd = 1;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 1 || exc_cause !== 5'd4 ||
        exc_pc !== 32'h0040_0003 || exc_bd !== 1 ||
        exc_badvaddr !== 32'h0040_0003) begin
      n_bad++;
      $display("FAIL fetch_adel: got v=%0b c=%0d pc=%0h bd=%0b bv=%0h want 1 4 400003 1 400003",
               exc_valid, exc_cause, exc_pc, exc_bd, exc_badvaddr);
    end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_irq_defer();
    clear_inputs();
    irq = 1;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 0) begin
      n_bad++;
      $display("FAIL irq_bubble: got v=%0b want 0", exc_valid);
    end
    tick();
    irq = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (irq_pending !== 1 || exc_valid !== 0 ||
          exc_in_pipeline !== 1) begin
        n_bad++;
        $display("FAIL irq_wait%0d: got q=%0b v=%0b p=%0b want 1 0 1",
                 i, irq_pending, exc_valid, exc_in_pipeline);
      end
      tick();
    end
    m_valid = 1; m_pc = 32'h0040_0020;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 1 || exc_cause !== 5'd0 ||
        exc_pc !== 32'h0040_0020) begin
      n_bad++;
      $display("FAIL irq_fire: got v=%0b c=%0d pc=%0h want 1 0 400020",
               exc_valid, exc_cause, exc_pc);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (irq_pending !== 0) begin
      n_bad++;
      $display("FAIL irq_cleared: got q=%0b want 0", irq_pending);
    end
    tick();
    tick();
  endtask

  task automatic test_irq_wins_eret();
    clear_inputs();
    irq = 1; m_valid = 1; m_exc_ri = 1; m_pc = 32'h0040_0040;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 1 || exc_cause !== 5'd0) begin
      n_bad++;
      $display("FAIL irq_over_ri: got v=%0b c=%0d want 1 0",
               exc_valid, exc_cause);
    end
    tick();
    clear_inputs();
    tick();
    tick();
    m_valid = 1; m_is_eret = 1; m_pc = 32'h0040_0044;
    @(negedge clk);
    n_cmp++;
    if (exc_valid !== 1 || exc_cause !== 5'd31 || flush !== 0) begin
      n_bad++;
      $display("FAIL eret: got v=%0b c=%0d f=%0b want 1 31 0",
               exc_valid, exc_cause, flush);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (flush !== 1) begin
      n_bad++;
      $display("FAIL eret_flush: got f=%0b want 1", flush);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    m_valid = 1; m_exc_sys = 1; m_pc = 32'h0040_0080;
    tick();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (flush !== 0 || irq_pending !== 0 || exc_valid !== 0) begin
      n_bad++;
      $display("FAIL rst_in_flush: got f=%0b q=%0b v=%0b want 0 0 0",
               flush, irq_pending, exc_valid);
    end
    tick();
    irq = 1;
    tick();
    irq = 0;
    reset = 1;
    tick();
    reset = 0;
    m_valid = 1; m_pc = 32'h0040_0090;
    @(negedge clk);
    n_cmp++;
    if (flush !== 0 || irq_pending !== 0 || exc_valid !== 0) begin
      n_bad++;
      $display("FAIL rst_in_wait: got f=%0b q=%0b v=%0b want 0 0 0",
               flush, irq_pending, exc_valid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(99) < 2);
      m_valid      = ($urandom_range(99) < 70);
      m_pc         = $urandom;
      m_is_bd      = $urandom_range(1);
      m_exc_fetch  = ($urandom_range(99) < 8);
      m_exc_ri     = ($urandom_range(99) < 8);
      m_exc_sys    = ($urandom_range(99) < 8);
      m_exc_bp     = ($urandom_range(99) < 8);
      m_exc_ov     = ($urandom_range(99) < 8);
      m_exc_load   = ($urandom_range(99) < 8);
      m_exc_store  = ($urandom_range(99) < 8);
      m_is_eret    = ($urandom_range(99) < 8);
      m_data_addr  = $urandom;
      upstream_exc = ($urandom_range(99) < 20);
      irq          = ($urandom_range(99) < 10);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (exc_valid !== e_valid || flush !== e_flush ||
          exc_in_pipeline !== e_inp || irq_pending !== e_pend) begin
        n_bad++;
        $display("FAIL rnd_ctl[%0d]: got v=%0b f=%0b p=%0b q=%0b want %0b %0b %0b %0b",
                 n, exc_valid, flush, exc_in_pipeline, irq_pending,
                 e_valid, e_flush, e_inp, e_pend);
      end
      if (e_valid) begin
        n_cmp++;
        if (exc_cause !== e_cause || exc_pc !== e_pc ||
            exc_bd !== e_bd || exc_badvaddr !== e_badv) begin
          n_bad++;
          $display("FAIL rnd_evt[%0d]: got c=%0d pc=%0h bd=%0b bv=%0h want %0d %0h %0b %0h",
                   n, exc_cause, exc_pc, exc_bd, exc_badvaddr,
                   e_cause, e_pc, e_bd, e_badv);
        end
      end
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    #1;
    test_reset();
    test_overflow();
    test_fetch();
    test_irq_defer();
    test_irq_wins_eret();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
